// File: rtl/gcd_wb_master_if.sv
// Wishbone classic bus between the GCD job master and the GCD slave register map.
interface gcd_wb_master_if #(
  parameter int unsigned Dw   = 32,
  parameter int unsigned Aw   = 5,
  parameter int unsigned TAGw = 3,
  parameter int unsigned SELw = 4
);
  logic [Dw-1:0]   m_dat_o;
  logic [SELw-1:0] m_sel_o;
  logic [Aw-1:0]   m_addr_o;
  logic [TAGw-1:0] m_tag_o;
  logic            m_stb_o;
  logic            m_cyc_o;
  logic            m_we_o;
  logic [Dw-1:0]   m_dat_i;
  logic            m_ack_i;
  logic            m_err_i;
  logic            m_rty_i;

  modport master (
    output m_dat_o, m_sel_o, m_addr_o, m_tag_o, m_stb_o, m_cyc_o, m_we_o,
    input  m_dat_i, m_ack_i, m_err_i, m_rty_i
  );

  modport slave (
    input  m_dat_o, m_sel_o, m_addr_o, m_tag_o, m_stb_o, m_cyc_o, m_we_o,
    output m_dat_i, m_ack_i, m_err_i, m_rty_i
  );
endinterface

// File: rtl/gcd_wb_master.sv
// Drives one GCD job over Wishbone: write both operands, wait, poll the done flag,
// then read the result. Requires Dw >= GCDw.
module gcd_wb_master #(
  parameter int unsigned GCDw      = 32,
  parameter int unsigned Dw        = GCDw,
  parameter int unsigned Aw        = 5,
  parameter int unsigned TAGw      = 3,
  parameter int unsigned SELw      = 4,
  parameter int unsigned START_GAP = 4,
  parameter int unsigned MAX_POLL  = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [GCDw-1:0] in1_i,
  input  logic [GCDw-1:0] in2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [GCDw-1:0] gcd_o,
  gcd_wb_master_if.master wb
);

  localparam int unsigned GAP_W    = (START_GAP > 1) ? $clog2(START_GAP) : 1;
  localparam int unsigned GAP_LAST = (START_GAP > 0) ? (START_GAP - 1) : 0;
  localparam int unsigned POLL_W   = $clog2(MAX_POLL + 1);

  localparam logic [Aw-1:0] ADDR_STATUS = Aw'(0);
  localparam logic [Aw-1:0] ADDR_IN1    = Aw'(1);
  localparam logic [Aw-1:0] ADDR_IN2    = Aw'(2);
  localparam logic [Aw-1:0] ADDR_RES    = Aw'(3);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR1   = 3'd1,
    S_WR2   = 3'd2,
    S_WAIT  = 3'd3,
    S_POLL  = 3'd4,
    S_RDRES = 3'd5
  } state_e;

  state_e            state_q;
  logic [GCDw-1:0]   in1_q;
  logic [GCDw-1:0]   in2_q;
  logic [POLL_W-1:0] poll_q;
  logic [POLL_W-1:0] poll_d;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_d;
  logic              stb_q;
  logic              we_q;
  logic [Aw-1:0]     addr_q;
  logic [Dw-1:0]     dat_q;

  logic              we_d;
  logic [Aw-1:0]     addr_d;
  logic [Dw-1:0]     dat_d;
  logic              err_hit_c;
  logic              ack_hit_c;
  logic              rty_hit_c;
  logic              poll_limit_c;

  // Cycle and strobe share one register; select and tag are fixed.
  assign wb.m_stb_o  = stb_q;
  assign wb.m_cyc_o  = stb_q;
  assign wb.m_we_o   = we_q;
  assign wb.m_addr_o = addr_q;
  assign wb.m_dat_o  = dat_q;
  assign wb.m_sel_o  = {SELw{1'b1}};
  assign wb.m_tag_o  = '0;

  // Terminations only count while strobing; err beats ack, ack beats rty.
  always_comb begin
    err_hit_c    = stb_q & wb.m_err_i;
    ack_hit_c    = stb_q & wb.m_ack_i & ~wb.m_err_i;
    rty_hit_c    = stb_q & wb.m_rty_i & ~wb.m_ack_i & ~wb.m_err_i;
    poll_d       = poll_q + POLL_W'(1);
    gap_d        = gap_q + GAP_W'(1);
    poll_limit_c = (poll_d >= POLL_W'(MAX_POLL));
  end

  // Transaction the current bus state wants to issue.
  always_comb begin
    addr_d = '0;
    we_d   = 1'b0;
    dat_d  = '0;
    case (state_q)
      S_WR1: begin
        addr_d = ADDR_IN1;
        we_d   = 1'b1;
        dat_d  = Dw'(in1_q);
      end
      S_WR2: begin
        addr_d = ADDR_IN2;
        we_d   = 1'b1;
        dat_d  = Dw'(in2_q);
      end
      S_POLL:  addr_d = ADDR_STATUS;
      S_RDRES: addr_d = ADDR_RES;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      poll_q  <= '0;
      gap_q   <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      gcd_o   <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            in1_q   <= in1_i;
            in2_q   <= in2_i;
            poll_q  <= '0;
            gap_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= S_WR1;
          end
        end

        S_WAIT: begin
          if (gap_q >= GAP_W'(GAP_LAST)) begin
            gap_q   <= '0;
            state_q <= S_POLL;
          end else begin
            gap_q <= gap_d;
          end
        end

        S_WR1, S_WR2, S_POLL, S_RDRES: begin
          if (!stb_q) begin
            // Bus was idle for at least one cycle: (re)issue this state's access.
            stb_q  <= 1'b1;
            we_q   <= we_d;
            addr_q <= addr_d;
            dat_q  <= dat_d;
          end else if (err_hit_c) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= S_IDLE;
          end else if (ack_hit_c) begin
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            case (state_q)
              S_WR1: state_q <= S_WR2;
              S_WR2: begin
                gap_q   <= '0;
                state_q <= S_WAIT;
              end
              S_POLL: begin
                if (wb.m_dat_i[0]) begin
                  state_q <= S_RDRES;
                end else if (poll_limit_c) begin
                  err_o   <= 1'b1;
                  busy_o  <= 1'b0;
                  state_q <= S_IDLE;
                end else begin
                  poll_q <= poll_d;
                end
              end
              default: begin
                gcd_o   <= wb.m_dat_i[GCDw-1:0];
                done_o  <= 1'b1;
                busy_o  <= 1'b0;
                state_q <= S_IDLE;
              end
            endcase
          end else if (rty_hit_c) begin
            stb_q <= 1'b0;
            we_q  <= 1'b0;
          end
        end

        default: begin
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_wb_master.sv
// Directed bench for gcd_wb_master: a register-map slave model answers the bus,
// expected bus accesses and job results are queued and checked by monitors.
module tb_gcd_wb_master;
  localparam int unsigned GW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned TW = 3;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_i = 1'b0;
  logic [GW-1:0] in1_i = '0;
  logic [GW-1:0] in2_i = '0;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [GW-1:0] gcd_o;

  gcd_wb_master_if #(.Dw(DW), .Aw(AW), .TAGw(TW), .SELw(SW)) bus ();

  gcd_wb_master #(
    .GCDw(GW), .Dw(DW), .Aw(AW), .TAGw(TW), .SELw(SW), .START_GAP(4), .MAX_POLL(8)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .in1_i(in1_i), .in2_i(in2_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .gcd_o(gcd_o), .wb(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] dat;
  } bus_t;

  typedef struct packed {
    logic          is_err;
    logic [GW-1:0] gcd;
  } res_t;

  bus_t exp_bus[$];
  res_t exp_res[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Slave behaviour knobs
  int ws = 1;
  int done_after = 2;
  bit done_never = 1'b0;
  bit err_poll = 1'b0;
  int rty_wr1 = 0;
  bit spur = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] euclid(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic push_bus(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] dat);
    bus_t e;
    e.addr = addr;
    e.we   = we;
    e.dat  = dat;
    exp_bus.push_back(e);
  endtask

  task automatic push_polls(input int n);
    for (int i = 0; i < n; i++) push_bus(AW'(0), 1'b0, '0);
  endtask

  task automatic push_res(input logic is_err, input logic [GW-1:0] g);
    res_t r;
    r.is_err = is_err;
    r.gcd    = g;
    exp_res.push_back(r);
  endtask

  // Slave model plus bus-side monitor; decisions made at negedge for the next posedge.
  logic [31:0] s_in1 = '0;
  logic [31:0] s_in2 = '0;
  int          s_polls = 0;
  int          cnt = 0;
  bit          gap_chk = 1'b0;
  bus_t        cap;

  always @(negedge clk) begin : slave
    bus_t got;
    bus_t e;
    bus.m_ack_i = 1'b0;
    bus.m_err_i = 1'b0;
    bus.m_rty_i = 1'b0;
    bus.m_dat_i = '0;
    if (gap_chk) begin
      check("idle_gap", 32'(bus.m_stb_o), 32'd0);
      gap_chk = 1'b0;
    end
    if (!bus.m_stb_o) begin
      cnt = 0;
      if (spur) begin
        bus.m_ack_i = 1'b1;
        bus.m_err_i = 1'b1;
        bus.m_rty_i = 1'b1;
        bus.m_dat_i = 32'd1;
      end
    end else begin
      got.addr = bus.m_addr_o;
      got.we   = bus.m_we_o;
      got.dat  = bus.m_dat_o;
      if (cnt == 0) cap = got;
      if (cnt < ws) begin
        cnt++;
      end else begin
        check("bus_stable", 32'(got), 32'(cap));
        check("cyc_sel_tag", {28'd0, bus.m_cyc_o, bus.m_sel_o[2:0]} ^ {29'd0, bus.m_tag_o},
              {28'd0, 1'b1, 3'b111});
        if (exp_bus.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL bus_unexpected: got addr=%0d we=%0b dat=0x%0h, want none",
                   got.addr, got.we, got.dat);
        end else begin
          e = exp_bus.pop_front();
          check("bus_addr", 32'(got.addr), 32'(e.addr));
          check("bus_we", 32'(got.we), 32'(e.we));
          check("bus_dat", got.dat, e.dat);
        end
        if (rty_wr1 > 0 && got.we && got.addr == AW'(1)) begin
          bus.m_rty_i = 1'b1;
          rty_wr1--;
        end else if (err_poll && !got.we && got.addr == AW'(0)) begin
          bus.m_err_i = 1'b1;
          bus.m_ack_i = 1'b1;
          bus.m_dat_i = 32'd1;
        end else begin
          bus.m_ack_i = 1'b1;
          if (got.we) begin
            if (got.addr == AW'(1)) s_in1 = got.dat;
            if (got.addr == AW'(2)) begin
              s_in2   = got.dat;
              s_polls = 0;
            end
          end else if (got.addr == AW'(0)) begin
            bus.m_dat_i = {31'd0, (!done_never && s_polls >= done_after)};
            s_polls++;
          end else if (got.addr == AW'(3)) begin
            bus.m_dat_i = euclid(s_in1, s_in2);
          end
        end
        gap_chk = 1'b1;
        cnt = 0;
      end
    end
  end

  // Result monitor: every done/err pulse must match the next queued outcome.
  always @(posedge clk) begin : res_mon
    res_t r;
    #1;
    if (done_o || err_o) begin
      check("pulse_excl", 32'(done_o & err_o), 32'd0);
      check("busy_at_pulse", 32'(busy_o), 32'd0);
      if (exp_res.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pulse_unexpected: got done=%0b err=%0b, want none", done_o, err_o);
      end else begin
        r = exp_res.pop_front();
        check("pulse_kind", 32'(err_o), 32'(r.is_err));
        check("gcd_o", gcd_o, r.gcd);
      end
    end
  end

  task automatic run_job(input logic [GW-1:0] a, input logic [GW-1:0] b);
    @(posedge clk);
    #2;
    start_i = 1'b1;
    in1_i   = a;
    in2_i   = b;
    @(posedge clk);
    #2;
    start_i = 1'b0;
    check("busy_set", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (exp_res.size() == 0 && exp_bus.size() == 0 && !busy_o) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s_timeout: got busy=%0b pending=%0d, want idle", name, busy_o,
             exp_res.size() + exp_bus.size());
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_bus"}, {29'd0, bus.m_stb_o, bus.m_cyc_o, bus.m_we_o}, 32'd0);
    check({tag, "_flags"}, {29'd0, busy_o, done_o, err_o}, 32'd0);
    check({tag, "_gcd"}, gcd_o, 32'd0);
    check({tag, "_addr"}, 32'(bus.m_addr_o), 32'd0);
    check({tag, "_dat"}, bus.m_dat_o, 32'd0);
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #2;
    check_cleared("reset");
    reset = 1'b1;

    // Plain job 48/18 -> 6, two not-done polls first
    push_bus(AW'(1), 1'b1, 32'd48);
    push_bus(AW'(2), 1'b1, 32'd18);
    push_polls(3);
    push_bus(AW'(3), 1'b0, '0);
    push_res(1'b0, 32'd6);
    run_job(32'd48, 32'd18);
    wait_done("basic", 300);

    // First WR1 gets a retry and is reissued unchanged
    rty_wr1 = 1;
    push_bus(AW'(1), 1'b1, 32'd48);
    push_bus(AW'(1), 1'b1, 32'd48);
    push_bus(AW'(2), 1'b1, 32'd18);
    push_polls(3);
    push_bus(AW'(3), 1'b0, '0);
    push_res(1'b0, 32'd6);
    run_job(32'd48, 32'd18);
    wait_done("retry", 300);

    // Error (with simultaneous ack) on the first poll aborts, gcd_o keeps 6
    err_poll = 1'b1;
    push_bus(AW'(1), 1'b1, 32'd48);
    push_bus(AW'(2), 1'b1, 32'd18);
    push_polls(1);
    push_res(1'b1, 32'd6);
    run_job(32'd48, 32'd18);
    wait_done("err_poll", 300);
    err_poll = 1'b0;

    // Done never set: exactly 8 polls then timeout error
    done_never = 1'b1;
    push_bus(AW'(1), 1'b1, 32'd48);
    push_bus(AW'(2), 1'b1, 32'd18);
    push_polls(8);
    push_res(1'b1, 32'd6);
    run_job(32'd48, 32'd18);
    wait_done("max_poll", 400);
    done_never = 1'b0;

    // start_i held with new operands 7/3 during a 100/75 job; stray terminations while idle
    spur = 1'b1;
    push_bus(AW'(1), 1'b1, 32'd100);
    push_bus(AW'(2), 1'b1, 32'd75);
    push_polls(3);
    push_bus(AW'(3), 1'b0, '0);
    push_res(1'b0, 32'd25);
    @(posedge clk);
    #2;
    start_i = 1'b1;
    in1_i   = 32'd100;
    in2_i   = 32'd75;
    @(posedge clk);
    #2;
    in1_i = 32'd7;
    in2_i = 32'd3;
    repeat (10) @(posedge clk);
    #2;
    start_i = 1'b0;
    wait_done("start_held", 300);
    spur = 1'b0;

    // Reset while WR2 is strobing, then a fresh job 0x21/0x0C -> 3
    ws = 3;
    push_bus(AW'(1), 1'b1, 32'd48);
    run_job(32'd48, 32'd18);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #2;
      if (bus.m_stb_o && bus.m_addr_o == AW'(2)) found = 1'b1;
    end
    check("wr2_reached", 32'(found), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #2;
    check_cleared("midreset");
    reset = 1'b1;
    ws = 1;
    push_bus(AW'(1), 1'b1, 32'h21);
    push_bus(AW'(2), 1'b1, 32'h0C);
    push_polls(3);
    push_bus(AW'(3), 1'b0, '0);
    push_res(1'b0, 32'd3);
    run_job(32'h21, 32'h0C);
    wait_done("after_reset", 300);

    repeat (5) @(posedge clk);
    #2;
    check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
    check("res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gcd_wb_master.md
GCD_WB_MASTER -- requirements
Module: gcd_wb_master

Interface
REQ-001 SHALL have parameter GCDw, default 32, operand/result width.
REQ-002 SHALL have parameter Dw, default GCDw, Wishbone data width.
REQ-003 SHALL have parameters Aw=5, TAGw=3, SELw=4: Wishbone address, tag and select widths.
REQ-004 SHALL have parameter START_GAP, default 4, idle cycles between the in2 write and the first poll.
REQ-005 SHALL have parameter MAX_POLL, default 1024, poll reads allowed before timeout.
REQ-006 SHALL have ports clk, input, 1, clock; reset, input, 1, reset (one clock; reset is synchronous and active-low).
REQ-007 SHALL have ports start_i (input, 1, job request), in1_i and in2_i (input, GCDw, operands).
REQ-008 SHALL have ports busy_o (output, 1), done_o (output, 1, one-cycle completion pulse), err_o (output, 1, one-cycle failure pulse), gcd_o (output, GCDw, result).
REQ-009 SHALL have Wishbone master outputs m_dat_o (Dw), m_sel_o (SELw), m_addr_o (Aw), m_tag_o (TAGw), m_stb_o, m_cyc_o, m_we_o.
REQ-010 SHALL have Wishbone master inputs m_dat_i (Dw), m_ack_i, m_err_i, m_rty_i.

Function
REQ-011 SHALL target the GCD slave map: 0 done status (bit0), 1 in1, 2 in2 (write starts computation), 3 gcd result.
REQ-012 SHALL use states IDLE, WR1, WR2, WAIT, POLL, RDRES.
REQ-013 SHALL, in IDLE with start_i=1 at a clock edge, latch in1_i/in2_i, set busy_o and enter WR1; start_i is ignored outside IDLE.
REQ-014 SHALL assert m_cyc_o/m_stb_o from the cycle after entering a bus state, holding m_addr_o, m_we_o and m_dat_o stable until m_ack_i, m_err_i or m_rty_i is sampled high.
REQ-015 SHALL drive m_sel_o all-ones, m_tag_o zero, and m_dat_o zero on reads.
REQ-016 SHALL deassert m_stb_o/m_cyc_o in the cycle after a sampled termination, giving at least one idle bus cycle between transactions.
REQ-017 WR1 SHALL write latched in1 to address 1; on ack go to WR2.
REQ-018 WR2 SHALL write latched in2 to address 2; on ack go to WAIT.
REQ-019 WAIT SHALL count START_GAP cycles with the bus idle, then go to POLL.
REQ-020 POLL SHALL read address 0; on ack with m_dat_i[0]=1 go to RDRES; on ack with bit0=0 increment the poll counter and reissue the read.
REQ-021 RDRES SHALL read address 3; on ack load gcd_o from m_dat_i[GCDw-1:0], pulse done_o for one cycle, clear busy_o and return to IDLE.
REQ-022 On m_rty_i, SHALL end the cycle and reissue the identical transaction after one idle cycle; retries are unlimited and not counted as polls.
REQ-023 On m_err_i in any bus state, SHALL abort: pulse err_o, clear busy_o, return to IDLE, gcd_o unchanged.
REQ-024 When the poll counter reaches MAX_POLL without done, SHALL abort as in REQ-023.
REQ-025 If m_ack_i and m_err_i are high together, SHALL give err priority; ack takes priority over rty.
REQ-026 SHALL ignore m_ack_i/m_err_i/m_rty_i while m_stb_o=0.
REQ-027 done_o and err_o SHALL never be high in the same cycle; busy_o SHALL fall in the same cycle as that pulse.

Reset
REQ-028 With reset=0 at a clock edge, SHALL enter IDLE and clear all outputs (m_stb_o, m_cyc_o, m_we_o, busy_o, done_o, err_o, gcd_o, m_addr_o, m_dat_o) plus poll and gap counters.
REQ-029 Reset mid-transaction SHALL drop m_cyc_o/m_stb_o on the next edge with no pulse on done_o or err_o.

Verification
REQ-030 in1=48, in2=18 against the GCD slave model -> writes addr1=48 then addr2=18, polls addr0 until bit0=1, reads addr3, gcd_o=6, single done_o pulse.
REQ-031 Slave returns m_rty_i on the first WR1 attempt -> one idle cycle, WR1 reissued with addr1 and data 48, job still completes with gcd_o=6.
REQ-032 m_err_i during POLL -> err_o pulses once, busy_o clears, gcd_o keeps previous value 6, no done_o.
REQ-033 MAX_POLL=8 with done held at 0 -> exactly 8 poll reads issued, then err_o pulse.
REQ-034 start_i held high during a busy job with in1=7, in2=3 -> ignored; the in-flight job completes with its own operands.
REQ-035 reset=0 while m_stb_o=1 in WR2 -> bus released next edge, all outputs zero, no pulses; a new start (in1=0x21, in2=0x0C) completes with gcd_o=3.
